// File: rtl/snes_map_pkg.sv
// Shared constants and types for the SNES cartridge address mapper.
package snes_map_pkg;

    localparam logic [2:0] MAPPER_HIROM = 3'd0;
    localparam logic [2:0] MAPPER_LOROM = 3'd1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SNES = 2'd1,
        ST_MCU  = 2'd2
    } state_t;

    // HiROM SaveRAM lives at offsets 6000-7FFF; LoROM SaveRAM in banks x0-xD.
    localparam logic [15:0] HIROM_SRAM_LO       = 16'h6000;
    localparam logic [15:0] HIROM_SRAM_HI       = 16'h7FFF;
    localparam logic [3:0]  LOROM_SRAM_BANK_LIM = 4'hE;

endpackage

// File: rtl/snes_addr_decode.sv
// Combinational SNES address translation: mapper window decode, size masking
// and SaveRAM base placement into one flat physical byte address.
module snes_addr_decode
    import snes_map_pkg::*;
#(
    parameter int                ADDR_W       = 23,
    parameter logic [ADDR_W-1:0] SAVERAM_BASE = 23'h600000
) (
    input  logic [2:0]        mapper_i,
    input  logic [23:0]       snes_addr_i,
    input  logic              snes_cs_i,
    input  logic [ADDR_W-1:0] rom_mask_i,
    input  logic [ADDR_W-1:0] saveram_mask_i,
    output logic [ADDR_W-1:0] phys_o,
    output logic              is_rom_o,
    output logic              is_saveram_o
);

    logic hi_sav;
    logic lo_sav;
    logic any_rom;
    logic unused_bits;

    assign hi_sav = !snes_addr_i[22] && snes_addr_i[21]
                 && (snes_addr_i[15:0] >= HIROM_SRAM_LO)
                 && (snes_addr_i[15:0] <= HIROM_SRAM_HI);
    assign lo_sav = (snes_addr_i[22:20] == 3'b111)
                 && (snes_addr_i[19:16] < LOROM_SRAM_BANK_LIM)
                 && !snes_addr_i[15] && !snes_cs_i;
    assign any_rom = snes_addr_i[22] | snes_addr_i[15];
    assign unused_bits = snes_addr_i[23];

    always_comb begin
        phys_o       = '0;
        is_rom_o     = 1'b0;
        is_saveram_o = 1'b0;
        unique case (mapper_i)
            MAPPER_HIROM: begin
                if (hi_sav) begin
                    is_saveram_o = 1'b1;
                    phys_o = SAVERAM_BASE
                           | (ADDR_W'({snes_addr_i[20:16], snes_addr_i[12:0]}) & saveram_mask_i);
                end else if (any_rom) begin
                    is_rom_o = 1'b1;
                    phys_o   = ADDR_W'(snes_addr_i[22:0]) & rom_mask_i;
                end
            end
            MAPPER_LOROM: begin
                if (lo_sav) begin
                    is_saveram_o = 1'b1;
                    phys_o = SAVERAM_BASE
                           | (ADDR_W'({snes_addr_i[19:16], snes_addr_i[14:0]}) & saveram_mask_i);
                end else if (any_rom) begin
                    is_rom_o = 1'b1;
                    phys_o   = ADDR_W'({snes_addr_i[22:16], snes_addr_i[14:0]}) & rom_mask_i;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/snes_addr_map.sv
// SNES/MCU shared-SRAM address mapper and bus-phase arbiter (SNES has priority).
// Optional macro MCU_AUTOINC_EN: MCU address counter advances on every MCU_ACK.
module snes_addr_map
    import snes_map_pkg::*;
#(
    parameter int                ADDR_W       = 23,
    parameter int                CHIPS        = 4,
    parameter int                ACCESS_CYC   = 4,
    parameter logic [ADDR_W-1:0] SAVERAM_BASE = 23'h600000
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [2:0]                   MAPPER,
    input  logic [23:0]                  SNES_ADDR,
    input  logic                         SNES_CS,
    input  logic                         SNES_REQ,
    input  logic [23:0]                  MCU_ADDR,
    input  logic                         MCU_ADDR_WR,
    input  logic                         MCU_REQ,
    output logic                         MCU_ACK,
    input  logic [ADDR_W-1:0]            ROM_MASK,
    input  logic [ADDR_W-1:0]            SAVERAM_MASK,
    output logic [ADDR_W-2-$clog2(CHIPS):0] SRAM_ADDR,
    output logic                         SRAM_ADDR0,
    output logic                         SRAM_BHE,
    output logic                         SRAM_BLE,
    output logic [CHIPS-1:0]             ROM_SEL,
    output logic                         IS_ROM,
    output logic                         IS_SAVERAM,
    output logic                         MCU_PHASE,
    output logic                         BUSY
);

    localparam int         CHIP_W = $clog2(CHIPS);
    localparam int         SA_W   = ADDR_W - 1 - CHIP_W;
    localparam logic [3:0] LAST   = 4'(ACCESS_CYC - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              snes_pend_q, snes_pend_d;
    logic [23:0]       snes_addr_q, snes_addr_d;
    logic              snes_cs_q, snes_cs_d;
    logic [2:0]        mapper_q, mapper_d;
    logic [ADDR_W-1:0] mcu_cnt_q, mcu_cnt_d;
    logic [SA_W-1:0]   sram_addr_q, sram_addr_d;
    logic              sram_addr0_q, sram_addr0_d;
    logic              bhe_q, bhe_d, ble_q, ble_d;
    logic [CHIPS-1:0]  rom_sel_q, rom_sel_d;
    logic              is_rom_q, is_rom_d, is_sav_q, is_sav_d;
    logic              ack_q, ack_d, mcu_phase_q, mcu_phase_d;

    logic              enter_snes, enter_mcu, mapped;
    logic [23:0]       dec_addr;
    logic              dec_cs;
    logic [2:0]        dec_mapper;
    logic [ADDR_W-1:0] dec_phys, phys_n;
    logic              dec_is_rom, dec_is_sav;
    logic              unused_bits;

    // A request in this very cycle is decoded live; a pended one from its latch.
    assign dec_addr    = SNES_REQ ? SNES_ADDR : snes_addr_q;
    assign dec_cs      = SNES_REQ ? SNES_CS   : snes_cs_q;
    assign dec_mapper  = SNES_REQ ? MAPPER    : mapper_q;
    assign unused_bits = ^MCU_ADDR;

    snes_addr_decode #(
        .ADDR_W       (ADDR_W),
        .SAVERAM_BASE (SAVERAM_BASE)
    ) u_decode (
        .mapper_i       (dec_mapper),
        .snes_addr_i    (dec_addr),
        .snes_cs_i      (dec_cs),
        .rom_mask_i     (ROM_MASK),
        .saveram_mask_i (SAVERAM_MASK),
        .phys_o         (dec_phys),
        .is_rom_o       (dec_is_rom),
        .is_saveram_o   (dec_is_sav)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        enter_snes = 1'b0;
        enter_mcu  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (SNES_REQ)     enter_snes = 1'b1;
                else if (MCU_REQ) enter_mcu  = 1'b1;
            end
            default: begin
                if (cnt_q == LAST) begin
                    if (snes_pend_q || SNES_REQ)          enter_snes = 1'b1;
                    else if (MCU_REQ && state_q != ST_MCU) enter_mcu  = 1'b1;
                    else                                  state_d    = ST_IDLE;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
        endcase
        if (enter_snes) begin
            state_d = ST_SNES;
            cnt_d   = '0;
        end
        if (enter_mcu) begin
            state_d = ST_MCU;
            cnt_d   = '0;
        end

        snes_pend_d = snes_pend_q;
        if (enter_snes)                          snes_pend_d = 1'b0;
        else if (SNES_REQ && state_q != ST_IDLE) snes_pend_d = 1'b1;
        snes_addr_d = SNES_REQ ? SNES_ADDR : snes_addr_q;
        snes_cs_d   = SNES_REQ ? SNES_CS   : snes_cs_q;
        mapper_d    = SNES_REQ ? MAPPER    : mapper_q;

        mcu_cnt_d = mcu_cnt_q;
`ifdef MCU_AUTOINC_EN
        if (ack_q) mcu_cnt_d = mcu_cnt_q + 1'b1;
`endif
        if (MCU_ADDR_WR) mcu_cnt_d = MCU_ADDR[ADDR_W-1:0];

        phys_n       = enter_snes ? dec_phys : mcu_cnt_q;
        mapped       = enter_mcu | dec_is_rom | dec_is_sav;
        sram_addr_d  = sram_addr_q;
        sram_addr0_d = sram_addr0_q;
        bhe_d        = bhe_q;
        ble_d        = ble_q;
        rom_sel_d    = rom_sel_q;
        is_rom_d     = is_rom_q;
        is_sav_d     = is_sav_q;
        if (enter_snes || enter_mcu) begin
            sram_addr_d  = phys_n[ADDR_W-1-CHIP_W:1];
            sram_addr0_d = phys_n[0];
            is_rom_d     = enter_snes & dec_is_rom;
            is_sav_d     = enter_snes & dec_is_sav;
            if (mapped) begin
                rom_sel_d = ~({{(CHIPS-1){1'b0}}, 1'b1} << phys_n[ADDR_W-1 -: CHIP_W]);
                ble_d     = phys_n[0];
                bhe_d     = ~phys_n[0];
            end else begin
                rom_sel_d = '1;
                ble_d     = 1'b1;
                bhe_d     = 1'b1;
            end
        end else if (state_d == ST_IDLE) begin
            rom_sel_d = '1;
            ble_d     = 1'b1;
            bhe_d     = 1'b1;
            is_rom_d  = 1'b0;
            is_sav_d  = 1'b0;
        end
        mcu_phase_d = (state_d == ST_MCU);
        ack_d       = (state_d == ST_MCU) && (cnt_d == LAST);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            snes_pend_q  <= 1'b0;
            snes_addr_q  <= '0;
            snes_cs_q    <= 1'b1;
            mapper_q     <= '0;
            mcu_cnt_q    <= '0;
            sram_addr_q  <= '0;
            sram_addr0_q <= 1'b0;
            bhe_q        <= 1'b1;
            ble_q        <= 1'b1;
            rom_sel_q    <= '1;
            is_rom_q     <= 1'b0;
            is_sav_q     <= 1'b0;
            ack_q        <= 1'b0;
            mcu_phase_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            snes_pend_q  <= snes_pend_d;
            snes_addr_q  <= snes_addr_d;
            snes_cs_q    <= snes_cs_d;
            mapper_q     <= mapper_d;
            mcu_cnt_q    <= mcu_cnt_d;
            sram_addr_q  <= sram_addr_d;
            sram_addr0_q <= sram_addr0_d;
            bhe_q        <= bhe_d;
            ble_q        <= ble_d;
            rom_sel_q    <= rom_sel_d;
            is_rom_q     <= is_rom_d;
            is_sav_q     <= is_sav_d;
            ack_q        <= ack_d;
            mcu_phase_q  <= mcu_phase_d;
        end
    end

    assign SRAM_ADDR  = sram_addr_q;
    assign SRAM_ADDR0 = sram_addr0_q;
    assign SRAM_BHE   = bhe_q;
    assign SRAM_BLE   = ble_q;
    assign ROM_SEL    = rom_sel_q;
    assign IS_ROM     = is_rom_q;
    assign IS_SAVERAM = is_sav_q;
    assign MCU_ACK    = ack_q;
    assign MCU_PHASE  = mcu_phase_q;
    assign BUSY       = (state_q != ST_IDLE);

endmodule
